// File: rtl/shreg_share_if.sv
// Bundle of client-side and serial-chain signals for shreg_share_ctrl.
//
// Handshake: a requester raises req[i] and holds wdata steady until it sees
// gnt[i]. The controller samples req only while idle. gnt[i] stays high for
// the whole transfer, and done[i] pulses for one cycle with rdata valid.
// Dropping req after the grant does not cancel the transfer. A req that is
// still high in the next idle cycle starts a new transfer.
interface shreg_share_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       req;
    logic [WIDTH-1:0] wdata0;
    logic [WIDTH-1:0] wdata1;
    logic             ser_in;
    logic             ser_out;
    logic             shift_en;
    logic [1:0]       gnt;
    logic             busy;
    logic [WIDTH-1:0] rdata;
    logic [1:0]       done;

    // master: the clients plus the return side of the serial chain
    modport master (
        output req, wdata0, wdata1, ser_in,
        input  ser_out, shift_en, gnt, busy, rdata, done
    );

    // slave: the shared-chain controller
    modport slave (
        input  req, wdata0, wdata1, ser_in,
        output ser_out, shift_en, gnt, busy, rdata, done
    );
endinterface

// File: rtl/shreg_share_ctrl.sv
// Round-robin owner of one WIDTH-bit serial shift chain shared by two
// requesters. The block loads the winner's word, shifts it out LSB-first
// while capturing ser_in, then returns the captured word with a done pulse.
module shreg_share_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    shreg_share_if.slave bus,
    output logic [1:0] state_dbg
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] rdata_q;
    logic [CW-1:0]    cnt;
    logic [1:0]       gnt_q;
    logic             last_gnt;   // index of the previous owner
    logic             win;        // index of the arbitration winner
    logic             load;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        win = 1'b0;
        case (bus.req)
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_gnt;
            default: win = 1'b0;
        endcase
    end

    // Next shift-chain contents: return bit enters at the MSB
    always_comb begin
        shreg_next = {bus.ser_in, shreg[WIDTH-1:1]};
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM next state; a started transfer always runs to DONE
    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_LAST) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: load on grant, shift and count, capture result, release owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            rdata_q  <= '0;
            cnt      <= '0;
            gnt_q    <= 2'b00;
            last_gnt <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg <= win ? bus.wdata1 : bus.wdata0;
                        gnt_q <= win ? 2'b10 : 2'b01;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    shreg <= shreg_next;
                    // counter parks at its last value instead of wrapping
                    if (cnt == CNT_LAST) begin
                        rdata_q <= shreg_next;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    last_gnt <= gnt_q[1];
                    gnt_q    <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from flops only, so no input reaches them combinationally
    always_comb begin
        bus.busy     = (state != IDLE);
        bus.shift_en = (state == SHIFT);
        bus.ser_out  = (state == SHIFT) & shreg[0];
        bus.gnt      = gnt_q;
        bus.done     = (state == DONE) ? gnt_q : 2'b00;
        bus.rdata    = rdata_q;
        state_dbg    = state;
    end
endmodule

// File: tb/tb_shreg_share_ctrl.sv
// Directed bench for shreg_share_ctrl: an 8-bit instance and a 2-bit instance.
module tb_shreg_share_ctrl;
    logic clk;
    logic rst_n;
    logic loop8;
    logic ser_const;
    int   n_checks;
    int   n_fail;
    logic [7:0] word;
    logic [1:0] exp_gnt;

    logic [1:0] st8;
    logic [1:0] st2;

    shreg_share_if #(.WIDTH(8)) bus8 ();
    shreg_share_if #(.WIDTH(2)) bus2 ();

    shreg_share_ctrl #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus8),
        .state_dbg (st8)
    );

    shreg_share_ctrl #(.WIDTH(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus2),
        .state_dbg (st2)
    );

    // serial return: loopback or a constant level
    always_comb bus8.ser_in = loop8 ? bus8.ser_out : ser_const;
    assign bus2.ser_in = bus2.ser_out;

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        loop8      = 1'b0;
        ser_const  = 1'b0;
        bus8.req   = 2'b00;
        bus8.wdata0 = 8'h00;
        bus8.wdata1 = 8'h00;
        bus2.req   = 2'b00;
        bus2.wdata0 = 2'b00;
        bus2.wdata1 = 2'b00;

        // reset state
        tick();
        tick();
        chk("rst_gnt",      32'(bus8.gnt),      32'h0);
        chk("rst_busy",     32'(bus8.busy),     32'h0);
        chk("rst_shift_en", 32'(bus8.shift_en), 32'h0);
        chk("rst_ser_out",  32'(bus8.ser_out),  32'h0);
        chk("rst_done",     32'(bus8.done),     32'h0);
        chk("rst_rdata",    32'(bus8.rdata),    32'h0);
        chk("rst_state",    32'(st8),           32'h0);
        chk("rst2_busy",    32'(bus2.busy),     32'h0);
        rst_n = 1'b1;

        // loopback of 0xA5 through requester 0
        loop8       = 1'b1;
        bus8.wdata0 = 8'hA5;
        bus8.req    = 2'b01;
        word        = 8'hA5;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) bus8.req = 2'b00;
            chk("lb_gnt", 32'(bus8.gnt), 32'h1);
            if (c <= 8) begin
                chk("lb_shift_en", 32'(bus8.shift_en), 32'h1);
                chk("lb_ser_out",  32'(bus8.ser_out),  32'((word >> (c - 1)) & 8'h01));
                chk("lb_done_low", 32'(bus8.done),     32'h0);
            end else begin
                chk("lb_shift_end", 32'(bus8.shift_en), 32'h0);
                chk("lb_done",      32'(bus8.done),     32'h1);
                chk("lb_rdata",     32'(bus8.rdata),    32'hA5);
                chk("lb_state",     32'(st8),           32'h2);
            end
        end
        tick();
        chk("lb_idle_busy", 32'(bus8.busy),  32'h0);
        chk("lb_idle_gnt",  32'(bus8.gnt),   32'h0);
        chk("lb_idle_done", 32'(bus8.done),  32'h0);
        chk("lb_hold",      32'(bus8.rdata), 32'hA5);

        // constant-one return through requester 1
        loop8       = 1'b0;
        ser_const   = 1'b1;
        bus8.wdata1 = 8'h00;
        bus8.req    = 2'b10;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) bus8.req = 2'b00;
            chk("cr_gnt",  32'(bus8.gnt),  32'h2);
            chk("cr_done", 32'(bus8.done), (c == 9) ? 32'h2 : 32'h0);
        end
        chk("cr_rdata", 32'(bus8.rdata), 32'hFF);
        tick();
        chk("cr_idle", 32'(bus8.busy), 32'h0);

        // simultaneous requests held: grants alternate, one idle cycle between
        ser_const   = 1'b0;
        bus8.wdata0 = 8'h3C;
        bus8.wdata1 = 8'hC3;
        bus8.req    = 2'b11;
        exp_gnt     = 2'b01;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("rr_gnt",  32'(bus8.gnt),  32'(exp_gnt));
            chk("rr_busy", 32'(bus8.busy), 32'h1);
            for (int c = 2; c <= 9; c++) tick();
            chk("rr_done",  32'(bus8.done),  32'(exp_gnt));
            chk("rr_rdata", 32'(bus8.rdata), 32'h0);
            tick();
            chk("rr_gap_busy", 32'(bus8.busy), 32'h0);
            chk("rr_gap_done", 32'(bus8.done), 32'h0);
            exp_gnt = {exp_gnt[0], exp_gnt[1]};
            if (t == 3) bus8.req = 2'b00;
        end
        tick();
        chk("rr_stop", 32'(bus8.busy), 32'h0);

        // request dropped mid-transfer still completes
        loop8       = 1'b1;
        bus8.wdata0 = 8'h5A;
        bus8.req    = 2'b01;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 3) bus8.req = 2'b00;
            if (c == 2) bus8.wdata0 = 8'hFF;
            chk("dr_done", 32'(bus8.done), (c == 9) ? 32'h1 : 32'h0);
        end
        chk("dr_rdata", 32'(bus8.rdata), 32'h5A);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("dr_idle", 32'(bus8.busy), 32'h0);
        end

        // reset abort in cycle 4 of a requester-1 transfer
        bus8.wdata1 = 8'h77;
        bus8.req    = 2'b10;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) bus8.req = 2'b00;
        end
        chk("ab_shift_en", 32'(bus8.shift_en), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("ab_gnt",      32'(bus8.gnt),      32'h0);
        chk("ab_busy",     32'(bus8.busy),     32'h0);
        chk("ab_shift_en0", 32'(bus8.shift_en), 32'h0);
        chk("ab_ser_out",  32'(bus8.ser_out),  32'h0);
        chk("ab_done",     32'(bus8.done),     32'h0);
        chk("ab_rdata",    32'(bus8.rdata),    32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("ab_no_done", 32'(bus8.done), 32'h0);
        end
        bus8.wdata1 = 8'h81;
        bus8.req    = 2'b10;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) bus8.req = 2'b00;
            chk("ab2_done", 32'(bus8.done), (c == 9) ? 32'h2 : 32'h0);
        end
        chk("ab2_rdata", 32'(bus8.rdata), 32'h81);
        tick();

        // WIDTH=2 loopback of 2'b10
        bus2.wdata0 = 2'b10;
        bus2.req    = 2'b01;
        tick();
        bus2.req = 2'b00;
        chk("w2_shift1",  32'(bus2.shift_en), 32'h1);
        chk("w2_ser1",    32'(bus2.ser_out),  32'h0);
        tick();
        chk("w2_shift2",  32'(bus2.shift_en), 32'h1);
        chk("w2_ser2",    32'(bus2.ser_out),  32'h1);
        tick();
        chk("w2_shift3",  32'(bus2.shift_en), 32'h0);
        chk("w2_done",    32'(bus2.done),     32'h1);
        chk("w2_rdata",   32'(bus2.rdata),    32'h2);
        tick();
        chk("w2_idle",    32'(bus2.busy),     32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
